// File: rtl/demux_deserializer.sv
// Sequential 1:2**N demultiplexer: reassembles a qualified serial stream (a[0] first)
// into a W-bit word on a valid/ready register. Define DESER_PARITY_EN for a trailing even-parity bit.
module demux_deserializer #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               din_valid,
  input  logic               din,
  input  logic               out_ready,
  input  logic               overrun_clr,
  output logic [(1<<N)-1:0]  q,
  output logic               q_valid,
  output logic               busy,
  output logic [N-1:0]       s,
  output logic               overrun,
  output logic               parity_err
);
  localparam int W = 1 << N;

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  // Handshake: q is offered while q_valid=1; a transfer happens on any edge
  // with q_valid & out_ready. A completing word always loads, even over an
  // unconsumed one (flagged by overrun unless that same edge transfers).
  state_t         state_q, state_n;
  logic [N-1:0]   s_q, s_n;
  logic [W-2:0]   shadow_q, shadow_n;
  logic [W-1:0]   q_q, q_n;
  logic           qv_q, qv_n;
  logic           ovr_q, ovr_n;
  logic           complete;
  logic [W-1:0]   word_n;
`ifdef DESER_PARITY_EN
  logic           msb_q, msb_n;
  logic           perr_q, perr_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      shadow_q <= '0;
      q_q      <= '0;
      qv_q     <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef DESER_PARITY_EN
      msb_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      s_q      <= s_n;
      shadow_q <= shadow_n;
      q_q      <= q_n;
      qv_q     <= qv_n;
      ovr_q    <= ovr_n;
`ifdef DESER_PARITY_EN
      msb_q    <= msb_n;
      perr_q   <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n  = state_q;
    s_n      = s_q;
    shadow_n = shadow_q;
    complete = 1'b0;
    word_n   = {din, shadow_q};
`ifdef DESER_PARITY_EN
    msb_n    = msb_q;
    perr_n   = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && din_valid) begin
          shadow_n    = '0;
          shadow_n[0] = din;
          s_n         = N'(1);
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        // start resynchronises and outranks completion
        if (start) begin
          shadow_n = '0;
          if (din_valid) begin
            shadow_n[0] = din;
            s_n         = N'(1);
          end else begin
            s_n     = '0;
            state_n = IDLE;
          end
        end else if (din_valid) begin
          if (s_q == N'(W - 1)) begin
            s_n = '0;
`ifdef DESER_PARITY_EN
            msb_n   = din;
            state_n = PARITY;
`else
            complete = 1'b1;
            state_n  = IDLE;
`endif
          end else begin
            shadow_n[s_q] = din;
            s_n           = s_q + 1'b1;
          end
        end
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        if (start) begin
          shadow_n = '0;
          if (din_valid) begin
            shadow_n[0] = din;
            s_n         = N'(1);
            state_n     = SHIFT;
          end else begin
            s_n     = '0;
            state_n = IDLE;
          end
        end else if (din_valid) begin
          complete = 1'b1;
          word_n   = {msb_q, shadow_q};
          perr_n   = (^{msb_q, shadow_q}) ^ din;
          state_n  = IDLE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        s_n     = '0;
      end
    endcase

    q_n   = q_q;
    qv_n  = qv_q;
    ovr_n = ovr_q;
    if (overrun_clr) ovr_n = 1'b0;
    // set is evaluated after clear so a same-cycle set wins
    if (complete) begin
      q_n  = word_n;
      qv_n = 1'b1;
      if (qv_q && !out_ready) ovr_n = 1'b1;
    end else if (qv_q && out_ready) begin
      qv_n = 1'b0;
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    s       = s_q;
    q       = q_q;
    q_valid = qv_q;
    overrun = ovr_q;
`ifdef DESER_PARITY_EN
    parity_err = perr_q;
`else
    parity_err = 1'b0;
`endif
  end

endmodule

// File: doc/demux_deserializer.md
Name: demux_deserializer

Overview:
- Receive end of the serial link driven by the team's select-swept 2**N:1 multiplexer, which presents a[0] first, then a[1], and so on.
- Takes a qualified one-bit stream and routes each bit to the output position given by an internal select counter. This is a sequential 1:2**N demultiplexer.
- Reassembles the full 2**N-bit word and presents it on a valid/ready output register.
- Sits between a serial link and a parallel consumer.

Parameters:
- N, 3, select width; word width W = 2**N bits (default 8).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame start; qualifies din as bit 0 of a new word.
- din_valid  input  1  din carries a valid bit this cycle.
- din  input  1  serial data bit.
- out_ready  input  1  consumer accepts q this cycle.
- overrun_clr  input  1  clears the overrun flag.
- q  output  W  assembled word.
- q_valid  output  1  q holds an unconsumed word.
- busy  output  1  a frame is in progress (state is not IDLE).
- s  output  N  current select index (next bit position).
- overrun  output  1  sticky flag: an unconsumed word was overwritten.
- parity_err  output  1  parity failure on the last word; tied 0 without the optional feature.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - q=0, q_valid=0, busy=0, s=0, overrun=0, parity_err=0, shadow register=0, state=IDLE.
  - Reset overrides every other input, including mid-frame; the partial word is discarded.
- State IDLE:
  - Ignores din_valid unless start=1.
  - On start&din_valid: din goes to shadow[0], s becomes 1, state goes to SHIFT.
  - start without din_valid has no effect.
- State SHIFT:
  - On each din_valid: din goes to shadow[s], then s increments.
  - Cycles with din_valid=0 hold all state; gaps are unlimited.
- Word completion, when din_valid=1 and s=W-1:
  - At that edge, q gets {din, shadow[W-2:0]} and q_valid=1.
  - s wraps to 0 and state returns to IDLE. Latency: q is visible the cycle after the last bit is sampled.
- start while in SHIFT:
  - Resynchronises: the partial word is discarded.
  - If din_valid=1, din goes to shadow[0] and s=1. Otherwise s=0 and state goes to IDLE.
  - start takes priority over completion in the same cycle.
- Output handshake:
  - A transfer occurs when q_valid&out_ready. q_valid clears at that edge unless a new word completes in the same cycle.
  - Completion and transfer in the same cycle: the new word loads, q_valid stays 1, no overrun.
  - Completion while q_valid=1 and out_ready=0: q is overwritten with the new word and overrun is set.
- overrun:
  - Sticky; cleared only by reset or overrun_clr=1.
  - If set and clear happen in the same cycle, set wins.
- Widths:
  - s is N bits and wraps modulo W.
  - Shadow register is W-1 bits; bit W-1 is taken directly from din.

Optional Feature:
- Macro: DESER_PARITY_EN.
- With the macro defined:
  - After bit W-1, state goes to PARITY and no word is loaded yet.
  - The next din_valid bit is even parity over the W data bits.
  - At that edge: q/q_valid load as above, parity_err = (XOR of data bits) ^ din, and state returns to IDLE.
  - parity_err holds until the next word completes or reset.
  - start in PARITY resynchronises as it does in SHIFT.
  - Latency becomes W+1 valid bits.
- Without the macro: no PARITY state, and parity_err is constant 0.

Test Plan:
- Basic word: reset, then start=1 with din_valid=1 and bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles, out_ready=0.
  - Required: q=8'h4D and q_valid=1 the cycle after bit 7; busy=0; s=0; overrun=0.
- Gapped input: same bits as above, but with din_valid low for 2 cycles between every bit.
  - Required: q=8'h4D after the 8th valid bit; s steps 1..7 only on valid cycles.
- Overrun: send word 8'hFF then 8'h00 with out_ready=0 throughout.
  - Required: q=8'h00, q_valid=1, overrun=1.
  - Then overrun_clr pulse: overrun=0 and q is unchanged.
- Completion coincides with transfer: out_ready=1 on the same cycle the second word's last bit arrives.
  - Required: q_valid stays 1 and overrun=0.
- Resync and reset mid-frame:
  - Send 3 bits, then start with a new 8-bit frame 8'hA5. Required: q=8'hA5.
  - Separately, send 5 bits, assert reset for 1 cycle, then idle. Required: q_valid=0, s=0, busy=0, and no word produced.
- DESER_PARITY_EN defined:
  - Send 8'h4D then parity bit 0 (4 ones, even). Required: q=8'h4D, parity_err=0.
  - Repeat with parity bit 1. Required: parity_err=1.
